uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Standalone 8N1 serial receiver. It turns the asynchronous `rx` pin into bytes that are presented on a level-held `rxRdy`/`rxAck` handshake.
- It is the producer on the receive side of the UART host interface. Top-level logic such as the echo and loopback designs consumes `rxData` and acknowledges it.
- Idle line is high. Bits are LSB first. There is no parity bit. Each bit is sampled at its centre, counted in system clocks.

Parameters:
- CLKS_PER_BIT, 868, SYSCLK cycles per bit period (100 MHz / 115200). Must be ≥ 8.
- SYNC_STAGES, 2, flip-flops in the `rx` metastability synchroniser. Must be ≥ 2.

Ports:
- SYSCLK  in  1  system clock; all logic is on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input; idle high.
- rxData  out  8  received byte; valid while `rxRdy`=1.
- rxRdy  out  1  high while an unacknowledged byte is held.
- rxAck  in  1  consumer acknowledge, sampled on SYSCLK.
- rxOverrun  out  1  sticky; a byte was lost because `rxRdy` was still high.
- rxFrameErr  out  1  one-cycle pulse when the stop bit is sampled low.
- rxBusy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- **Reset:** the clock and reset are one SYSCLK domain with synchronous, active-high RESET. On RESET:
  - FSM goes to IDLE.
  - `rxData`=0, `rxRdy`=0, `rxOverrun`=0, `rxFrameErr`=0, `rxBusy`=0.
  - Synchroniser flops are preset to 1.
  - Reset mid-frame discards the partial byte. After reset, reception restarts only on a fresh falling edge.
- **Input path:** `rx` passes through SYNC_STAGES flops, giving `rx_s`. All decisions use `rx_s`. Pin-to-`rx_s` latency is SYNC_STAGES cycles.
- **Bit-period counter:** `cnt` is $clog2(CLKS_PER_BIT) bits wide and counts down to 0. A sample is taken on the cycle when `cnt`==0, and `cnt` is then reloaded.
- **FSM:**
  - **IDLE:** move to START when `rx_s` is 0 (low level while idle counts as a start edge). Load `cnt` = CLKS_PER_BIT/2 − 1 (integer division).
  - **START:** at `cnt`==0, sample `rx_s`.
    - If 1: false start, return to IDLE.
    - If 0: go to DATA with `bitIdx`=0 and `cnt` = CLKS_PER_BIT − 1.
  - **DATA:** at each `cnt`==0, shift `rx_s` into bit 7 of the shift register, moving it right (LSB first). Increment `bitIdx` and reload `cnt`. After the 8th sample, go to STOP and reload `cnt`.
  - **STOP:** at `cnt`==0, sample `rx_s`.
    - If 1: deliver the byte (see below) and go to IDLE.
    - If 0: pulse `rxFrameErr` for 1 cycle, do not deliver, and go to BREAK.
  - **BREAK:** wait until `rx_s`==1, then go to IDLE. This stops a held-low line from producing repeated frames.
- **Delivery** happens on the edge where the stop bit is sampled.
  - If `rxRdy`==0, or `rxAck`==1 on that same edge: `rxData` ← shift register and `rxRdy` ← 1.
  - Else (unacknowledged data pending): the new byte is dropped, `rxData` is unchanged, and `rxOverrun` ← 1.
- **Acknowledge:**
  - On any edge with `rxAck`=1 and `rxRdy`=1 (and no simultaneous delivery): `rxRdy` ← 0 and `rxOverrun` ← 0.
  - `rxAck` held high across several cycles is harmless.
  - `rxAck` while `rxRdy`=0 is ignored.
- **Data stability:** `rxData` is stable whenever `rxRdy`=1 until the ack edge.
- **End-to-end latency:** the start-bit falling edge at the pin to `rxRdy` high is SYNC_STAGES + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles, ±1.

Optional Feature:
- Macro: `UART_RX_MAJORITY_EN`.
- **Defined:** every bit decision (START, DATA and STOP) is the 2-of-3 majority of `rx_s`, taken at `cnt`==1, 0 and the cycle after 0. The state transition is deferred by that 1 cycle, which adds +1 cycle of latency. A single-cycle glitch at bit centre is rejected.
- **Undefined:** a single sample is taken at `cnt`==0, as above.

Test Plan (CLKS_PER_BIT=16, SYNC_STAGES=2):
- **Single byte.** Send 0xA5 as 8N1 and hold `rxAck`=0 → `rxRdy` rises within 2+8+144 ±1 cycles of the start edge, `rxData`=0xA5, `rxFrameErr`=0 throughout. Pulse `rxAck` for 1 cycle → `rxRdy` is 0 on the next cycle.
- **Overrun.** Send 0x12, then 0x34 with no ack → `rxData` stays 0x12 and `rxOverrun`=1. Ack → `rxRdy`=0 and `rxOverrun`=0. Send 0x56 → `rxData`=0x56.
- **Ack on the delivery edge.** Byte 0x01 is pending. Assert `rxAck` on the exact stop-sample edge of byte 0x02 → `rxData`=0x02, `rxRdy` stays 1, `rxOverrun`=0.
- **False start and framing error.**
  - Drive `rx` low for 4 cycles → returns to IDLE, no `rxRdy`.
  - Send 0xFF with a low stop bit, then hold low for 40 cycles → one `rxFrameErr` pulse, no `rxRdy`, no second frame until `rx` goes high.
- **Reset mid-frame.** Assert RESET during bit 3 of 0x5A, then send 0xC3 → all outputs are 0 after reset and only 0xC3 is delivered.
- **Majority (`UART_RX_MAJORITY_EN`).** Send 0x00 with a 1-cycle high glitch at the centre of bit 2 → `rxData`=0x00. The same stimulus without the macro gives `rxData`=0x04.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 serial receiver with a level-held rxRdy/rxAck output handshake.
// Define UART_RX_MAJORITY_EN to make each bit decision a 2-of-3 vote around the bit centre.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       SYSCLK,
    input  logic       RESET,
    input  logic       rx,
    output logic [7:0] rxData,
    output logic       rxRdy,
    input  logic       rxAck,
    output logic       rxOverrun,
    output logic       rxFrameErr,
    output logic       rxBusy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rxState_t;

    rxState_t state, stateNext;

    logic [SYNC_STAGES-1:0] syncFf;
    logic                   rxS;
    logic [CW-1:0]          cnt;
    logic                   cntZero;
    logic                   active;
    logic [2:0]             bitIdx;
    logic [7:0]             shReg;
    logic                   bitTick;
    logic                   bitVal;

    logic startLoad, idxClr, shiftEn, deliver, frameErr;

    // Preset to idle-high so a reset never looks like a start edge.
    always_ff @(posedge SYSCLK) begin
        if (RESET) syncFf <= '1;
        else       syncFf <= {syncFf[SYNC_STAGES-2:0], rx};
    end

    assign rxS     = syncFf[SYNC_STAGES-1];
    assign cntZero = (cnt == '0);
    assign active  = (state == START) || (state == DATA) || (state == STOP);

`ifdef UART_RX_MAJORITY_EN
    logic smpA, smpB, decPend;

    // Votes on the samples at cnt==1, cnt==0 and the cycle after; decision lands one cycle late.
    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            smpA    <= 1'b1;
            smpB    <= 1'b1;
            decPend <= 1'b0;
        end else begin
            decPend <= active && cntZero;
            if (cnt == CW'(1)) smpA <= rxS;
            if (cntZero)       smpB <= rxS;
        end
    end

    assign bitTick = decPend;
    assign bitVal  = (smpA & smpB) | (smpA & rxS) | (smpB & rxS);
`else
    assign bitTick = active && cntZero;
    assign bitVal  = rxS;
`endif

    always_ff @(posedge SYSCLK) begin
        if (RESET) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        startLoad = 1'b0;
        idxClr    = 1'b0;
        shiftEn   = 1'b0;
        deliver   = 1'b0;
        frameErr  = 1'b0;
        case (state)
            IDLE: begin
                if (!rxS) begin
                    stateNext = START;
                    startLoad = 1'b1;
                end
            end
            START: begin
                if (bitTick) begin
                    if (bitVal) begin
                        stateNext = IDLE;
                    end else begin
                        stateNext = DATA;
                        idxClr    = 1'b1;
                    end
                end
            end
            DATA: begin
                if (bitTick) begin
                    shiftEn = 1'b1;
                    if (bitIdx == 3'd7) stateNext = STOP;
                end
            end
            STOP: begin
                if (bitTick) begin
                    if (bitVal) begin
                        deliver   = 1'b1;
                        stateNext = IDLE;
                    end else begin
                        frameErr  = 1'b1;
                        stateNext = BREAK;
                    end
                end
            end
            BREAK: begin
                // Hold off until the line returns high so a stuck-low pin yields one error only.
                if (rxS) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            cnt    <= '0;
            bitIdx <= '0;
            shReg  <= '0;
        end else begin
            if (startLoad)   cnt <= HALF_LOAD;
            else if (active) cnt <= cntZero ? FULL_LOAD : cnt - 1'b1;
            if (idxClr)       bitIdx <= '0;
            else if (shiftEn) bitIdx <= bitIdx + 3'd1;
            if (shiftEn) shReg <= {bitVal, shReg[7:1]};
        end
    end

    // An ack on the delivery edge frees the holding register for the new byte.
    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            rxData     <= '0;
            rxRdy      <= 1'b0;
            rxOverrun  <= 1'b0;
            rxFrameErr <= 1'b0;
        end else begin
            rxFrameErr <= frameErr;
            if (deliver) begin
                if (!rxRdy || rxAck) begin
                    rxData <= shReg;
                    rxRdy  <= 1'b1;
                    if (rxAck) rxOverrun <= 1'b0;
                end else begin
                    rxOverrun <= 1'b1;
                end
            end else if (rxAck && rxRdy) begin
                rxRdy     <= 1'b0;
                rxOverrun <= 1'b0;
            end
        end
    end

    assign rxBusy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table of frames plus hand sequences for overrun, ack timing, errors and reset.
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int SS  = 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    logic       SYSCLK = 1'b0;
    logic       RESET  = 1'b1;
    logic       rx     = 1'b1;
    logic       rxAck  = 1'b0;
    logic [7:0] rxData;
    logic       rxRdy, rxOverrun, rxFrameErr, rxBusy;

    uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SS)) dut (
        .SYSCLK(SYSCLK), .RESET(RESET), .rx(rx), .rxData(rxData), .rxRdy(rxRdy),
        .rxAck(rxAck), .rxOverrun(rxOverrun), .rxFrameErr(rxFrameErr), .rxBusy(rxBusy)
    );

    always #5 SYSCLK = ~SYSCLK;

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        logic       expRdy;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         startCyc = 0;
    int         rdyCyc = 0;
    int         feCnt = 0;
    logic [7:0] expQ[$];
    bit         allowChange = 0;
    logic       prevRdy = 1'b0;
    logic [7:0] prevData = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge SYSCLK);
        cyc++;
    end

    // Scoreboard: each rising rxRdy pops one expected byte.
    initial forever begin
        @(negedge SYSCLK);
        if (rxRdy === 1'b1 && prevRdy !== 1'b1) begin
            rdyCyc = cyc;
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rdy: got data 0x%0h expected no delivery", rxData);
            end else begin
                chk("sb_data", int'(rxData), int'(expQ.pop_front()));
            end
        end
        if (prevRdy === 1'b1 && rxRdy === 1'b1 && !allowChange)
            chk("data_stable", int'(rxData), int'(prevData));
        if (rxFrameErr === 1'b1) feCnt++;
        prevRdy  = rxRdy;
        prevData = rxData;
    end

    task automatic sendFrame(input logic [7:0] d, input logic stopBit, input int gSlot);
        logic [9:0] bits;
        bits     = {stopBit, d, 1'b0};
        startCyc = cyc;
        for (int s = 0; s < 10; s++)
            for (int c = 0; c < CPB; c++) begin
                rx = (s == gSlot && c == CPB / 2) ? ~bits[s] : bits[s];
                @(negedge SYSCLK);
            end
    endtask

    task automatic waitRdy(input string name);
        int n;
        n = 0;
        while (rxRdy !== 1'b1 && n < 300) begin
            @(negedge SYSCLK);
            n++;
        end
        chk(name, int'(rxRdy), 1);
    endtask

    task automatic ackPulse();
        rxAck = 1'b1;
        @(negedge SYSCLK);
        rxAck = 1'b0;
        chk("ack_rdy_clr", int'(rxRdy), 0);
        chk("ack_ovr_clr", int'(rxOverrun), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[6];
        int         lat, fe0;
        logic [7:0] d;

        vecs[0] = '{8'hA5, 1'b1, 1'b1};
        vecs[1] = '{8'h00, 1'b1, 1'b1};
        vecs[2] = '{8'hFF, 1'b1, 1'b1};
        vecs[3] = '{8'h3C, 1'b1, 1'b1};
        vecs[4] = '{8'hFF, 1'b0, 1'b0};
        vecs[5] = '{8'h81, 1'b1, 1'b1};

        repeat (4) @(negedge SYSCLK);
        chk("rst_data", int'(rxData), 0);
        chk("rst_rdy", int'(rxRdy), 0);
        chk("rst_ovr", int'(rxOverrun), 0);
        chk("rst_fe", int'(rxFrameErr), 0);
        chk("rst_busy", int'(rxBusy), 0);
        RESET = 1'b0;
        repeat (3 * CPB) @(negedge SYSCLK);

        foreach (vecs[i]) begin
            fe0 = feCnt;
            if (vecs[i].expRdy) expQ.push_back(vecs[i].data);
            sendFrame(vecs[i].data, vecs[i].stopBit, -1);
            rx = 1'b1;
            if (vecs[i].expRdy) begin
                waitRdy("vec_rdy");
                lat = rdyCyc - startCyc;
                checks++;
                if (lat < 153 || lat > 156) begin
                    errors++;
                    $display("FAIL latency: got %0d cycles expected 153..156", lat);
                end
                chk("vec_fe_none", feCnt - fe0, 0);
                ackPulse();
            end else begin
                repeat (20) @(negedge SYSCLK);
                chk("vec_no_rdy", int'(rxRdy), 0);
                chk("vec_fe_once", feCnt - fe0, 1);
            end
            repeat (CPB) @(negedge SYSCLK);
        end

        // Overrun: second byte dropped while first is pending.
        expQ.push_back(8'h12);
        sendFrame(8'h12, 1'b1, -1);
        waitRdy("ovr_rdy1");
        sendFrame(8'h34, 1'b1, -1);
        repeat (4) @(negedge SYSCLK);
        chk("ovr_data_held", int'(rxData), 'h12);
        chk("ovr_flag", int'(rxOverrun), 1);
        chk("ovr_rdy_held", int'(rxRdy), 1);
        ackPulse();
        expQ.push_back(8'h56);
        sendFrame(8'h56, 1'b1, -1);
        waitRdy("ovr_rdy3");
        chk("ovr_next_data", int'(rxData), 'h56);
        ackPulse();

        // Ack on the exact stop-sample edge of the following byte.
        expQ.push_back(8'h01);
        sendFrame(8'h01, 1'b1, -1);
        waitRdy("ackd_rdy1");
        allowChange = 1;
        fork
            sendFrame(8'h02, 1'b1, -1);
            begin
                repeat (154 + MAJ) @(negedge SYSCLK);
                rxAck = 1'b1;
                @(negedge SYSCLK);
                rxAck = 1'b0;
            end
        join
        allowChange = 0;
        chk("ackd_data", int'(rxData), 'h02);
        chk("ackd_rdy", int'(rxRdy), 1);
        chk("ackd_ovr", int'(rxOverrun), 0);
        ackPulse();

        // Reset in the middle of bit 3 of 0x5A.
        d  = 8'h5A;
        rx = 1'b0;
        repeat (CPB) @(negedge SYSCLK);
        for (int b = 0; b < 3; b++) begin
            rx = d[b];
            repeat (CPB) @(negedge SYSCLK);
        end
        rx = d[3];
        repeat (CPB / 2) @(negedge SYSCLK);
        RESET = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge SYSCLK);
        chk("mrst_data", int'(rxData), 0);
        chk("mrst_rdy", int'(rxRdy), 0);
        chk("mrst_ovr", int'(rxOverrun), 0);
        chk("mrst_fe", int'(rxFrameErr), 0);
        chk("mrst_busy", int'(rxBusy), 0);
        RESET = 1'b0;
        repeat (3 * CPB) @(negedge SYSCLK);
        expQ.push_back(8'hC3);
        sendFrame(8'hC3, 1'b1, -1);
        waitRdy("mrst_rdy_c3");
        ackPulse();

        // False start: 4-cycle low pulse.
        rx = 1'b0;
        repeat (4) @(negedge SYSCLK);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge SYSCLK);
        chk("fs_busy", int'(rxBusy), 0);
        chk("fs_rdy", int'(rxRdy), 0);

        // Framing error followed by a held-low line.
        fe0 = feCnt;
        sendFrame(8'hFF, 1'b0, -1);
        repeat (40) @(negedge SYSCLK);
        chk("brk_fe_once", feCnt - fe0, 1);
        chk("brk_busy", int'(rxBusy), 1);
        chk("brk_rdy", int'(rxRdy), 0);
        rx = 1'b1;
        repeat (5) @(negedge SYSCLK);
        chk("brk_idle", int'(rxBusy), 0);
        repeat (2 * CPB) @(negedge SYSCLK);
        chk("brk_fe_still_once", feCnt - fe0, 1);

        // One-cycle high glitch at the centre of bit 2 of 0x00.
        expQ.push_back(MAJ ? 8'h00 : 8'h04);
        sendFrame(8'h00, 1'b1, 3);
        rx = 1'b1;
        waitRdy("glitch_rdy");
        chk("glitch_data", int'(rxData), MAJ ? 'h00 : 'h04);
        ackPulse();

        repeat (CPB) @(negedge SYSCLK);
        chk("sb_empty", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
